// File: rtl/mem_stage_mc.sv
// mem_stage_mc: pipeline memory stage in front of a multi-cycle data array.
// A load/store accepted in IDLE is latched and held for LATENCY BUSY cycles.
// The stage then commits the store or captures the load word, and pulses
// done for one DONE cycle. Misaligned or read+write requests raise a sticky
// err and are dropped without stalling.
module mem_stage_mc #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] aluResult,
   input  logic [DATA_W-1:0] writeData,
   output logic [DATA_W-1:0] readData,
   output logic              stall,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // BUSY lasts LATENCY cycles: the counter runs LATENCY-1 down to 0.
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]            state;
   logic [3:0]            count;
   logic                  op_write;
   logic [DEPTH_LOG2-1:0] idx;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W-1:0]     mem [0:(1 << DEPTH_LOG2) - 1];

   logic req;
   logic bad;
   logic last_busy;

   // Upper address bits are deliberately ignored so the array aliases.
   logic unused_addr;
   assign unused_addr = ^aluResult[ADDR_W-1:DEPTH_LOG2+1];

   assign req       = memRead | memWrite;
   assign bad       = (memRead & memWrite) | (req & aluResult[0]);
   assign last_busy = (state == ST_BUSY) && (count == 4'd0);

   // The pipeline is held while a good request is being accepted and throughout BUSY.
   assign stall = (state == ST_BUSY) || ((state == ST_IDLE) && req && !bad);
   assign done  = (state == ST_DONE);

   // Control FSM: accept, count down the latency, then capture the load result.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= 4'd0;
         readData <= '0;
         err      <= 1'b0;
         op_write <= 1'b0;
         idx      <= '0;
         wdata    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bad) begin
                  err <= 1'b1;
               end else if (req) begin
                  op_write <= memWrite;
                  idx      <= aluResult[DEPTH_LOG2:1];
                  wdata    <= writeData;
                  count    <= CNT_INIT;
                  state    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (count != 4'd0) begin
                  count <= count - 4'd1;
               end else begin
                  if (!op_write) readData <= mem[idx];
                  state <= ST_DONE;
               end
            end
            // Inputs still belong to the finished instruction, so they are not sampled here.
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Store commit on the last BUSY cycle; reset aborts a pending store because state leaves BUSY.
   // NOTE: the array has no reset so it can map onto block RAM; its contents survive rst.
   always_ff @(posedge clk) begin
      if (last_busy && op_write) mem[idx] <= wdata;
   end

endmodule
